// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [5:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair (radix-2 shift-add, restoring divide).
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide stays iterative.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     reset_n,
  muldiv_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [5:0] OpMult  = 6'b011000;
  localparam logic [5:0] OpMultu = 6'b011001;
  localparam logic [5:0] OpDiv   = 6'b011010;
  localparam logic [5:0] OpDivu  = 6'b011011;
  localparam logic [5:0] OpMthi  = 6'b010001;
  localparam logic [5:0] OpMtlo  = 6'b010011;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  // Multiply: {partial sum, remaining multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic               neg_res_q, neg_rem_q, divz_q, is_div_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.a[WIDTH-1];
  assign b_neg     = is_signed & bus.b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`endif

  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_next  = {div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0],
                      acc_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quot, fix_rem;
  assign fix_prod = neg_res_q ? -acc_q : acc_q;
  // Zero divisor leaves the raw remainder = |a|, so sign-correcting it restores a.
  assign fix_quot = divz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign fix_rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      is_div_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            case (bus.op)
              OpMthi: hi_q <= bus.a;
              OpMtlo: lo_q <= bus.a;
              OpMult, OpMultu: begin
                busy_q    <= 1'b1;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= 1'b0;
                divz_q    <= 1'b0;
                is_div_q  <= 1'b0;
                cnt_q     <= '0;
`ifdef MULDIV_FAST_MUL_EN
                acc_q     <= fast_prod;
                state_q   <= StFix;
`else
                acc_q     <= {{WIDTH{1'b0}}, a_mag};
                opb_q     <= b_mag;
                state_q   <= StMul;
`endif
              end
              OpDiv, OpDivu: begin
                busy_q    <= 1'b1;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                divz_q    <= (bus.b == '0);
                is_div_q  <= 1'b1;
                cnt_q     <= '0;
                acc_q     <= {{WIDTH{1'b0}}, a_mag};
                opb_q     <= b_mag;
                state_q   <= StDiv;
              end
              default: ;
            endcase
          end
        end
        StMul, StDiv: begin
`ifdef MULDIV_FAST_MUL_EN
          acc_q <= div_next;
`else
          acc_q <= (state_q == StMul) ? mul_next : div_next;
`endif
          if (cnt_q == CntW'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFix: begin
          if (is_div_q) begin
            hi_q <= fix_rem;
            lo_q <= fix_quot;
          end else begin
            hi_q <= fix_prod[2*WIDTH-1:WIDTH];
            lo_q <= fix_prod[WIDTH-1:0];
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit; expected HI/LO values are hand-computed.
module tb_muldiv_unit;

  localparam logic [5:0] OpMult  = 6'b011000;
  localparam logic [5:0] OpMultu = 6'b011001;
  localparam logic [5:0] OpDiv   = 6'b011010;
  localparam logic [5:0] OpDivu  = 6'b011011;
  localparam logic [5:0] OpMthi  = 6'b010001;
  localparam logic [5:0] OpMtlo  = 6'b010011;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulBusy = 1;
`else
  localparam int MulBusy = 33;
`endif
  localparam int DivBusy = 33;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one mult/div; optionally inject a MULT start at loop index inject_at while busy.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_busy, input int inject_at);
    int bc;
    bit seen;
    bc = 0;
    seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'h0BAD_F00D;
    check_eq({tag, " hi held"}, {32'h0, bus.hi}, {32'h0, model_hi});
    check_eq({tag, " lo held"}, {32'h0, bus.lo}, {32'h0, model_lo});
    for (int k = 0; k < 100; k++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) bc++;
      if (k == inject_at) begin
        bus.start = 1'b1;
        bus.op = OpMult;
        bus.a = 32'd9;
        bus.b = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_eq({tag, " done seen"}, {63'h0, seen}, 64'h1);
    check_eq({tag, " busy cycles"}, 64'(bc), 64'(exp_busy));
    check_eq({tag, " busy at done"}, {63'h0, bus.busy}, 64'h0);
    check_eq({tag, " hi"}, {32'h0, bus.hi}, {32'h0, exp_hi});
    check_eq({tag, " lo"}, {32'h0, bus.lo}, {32'h0, exp_lo});
    model_hi = exp_hi;
    model_lo = exp_lo;
    @(negedge clk);
    check_eq({tag, " done pulse"}, {63'h0, bus.done}, 64'h0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    #23;
    check_eq("reset busy", {63'h0, bus.busy}, 64'h0);
    check_eq("reset done", {63'h0, bus.done}, 64'h0);
    check_eq("reset hi", {32'h0, bus.hi}, 64'h0);
    check_eq("reset lo", {32'h0, bus.lo}, 64'h0);
    reset_n = 1'b1;

    run_op("mult neg", OpMult, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MulBusy, -1);
    run_op("multu max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, MulBusy, -1);
    run_op("mult negneg", OpMult, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'h0, 32'd35, MulBusy, -1);
    run_op("div -7/2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivBusy, -1);
    run_op("div 7/-2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DivBusy, -1);
    run_op("divu 7/2", OpDivu, 32'd7, 32'd2, 32'd1, 32'd3, DivBusy, -1);
    run_op("divu big", OpDivu, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, DivBusy, -1);
    run_op("div by 0", OpDiv, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DivBusy, -1);
    run_op("div ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DivBusy, -1);

    // MTHI / MTLO: single-cycle, no busy or done.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OpMthi;
    bus.a = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("mthi hi", {32'h0, bus.hi}, 64'h1234_5678);
    check_eq("mthi busy", {63'h0, bus.busy}, 64'h0);
    check_eq("mthi done", {63'h0, bus.done}, 64'h0);
    bus.start = 1'b1;
    bus.op = OpMtlo;
    bus.a = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("mtlo lo", {32'h0, bus.lo}, 64'h9ABC_DEF0);
    check_eq("mtlo hi kept", {32'h0, bus.hi}, 64'h1234_5678);
    model_hi = 32'h1234_5678;
    model_lo = 32'h9ABC_DEF0;

    // A MULT start arriving mid-divide must be dropped.
    run_op("div w/ inject", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, DivBusy, 4);

    // Invalid op is ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 6'b100000;
    bus.a = 32'h55;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("bad op busy", {63'h0, bus.busy}, 64'h0);
    check_eq("bad op hi", {32'h0, bus.hi}, {32'h0, model_hi});

    // Reset in the middle of a divide.
    bus.start = 1'b1;
    bus.op = OpDiv;
    bus.a = 32'd100;
    bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("rst mid busy", {63'h0, bus.busy}, 64'h0);
    check_eq("rst mid done", {63'h0, bus.done}, 64'h0);
    check_eq("rst mid hi", {32'h0, bus.hi}, 64'h0);
    check_eq("rst mid lo", {32'h0, bus.lo}, 64'h0);
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    begin
      bit stray;
      stray = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (bus.done || bus.busy) stray = 1'b1;
      end
      check_eq("no done after rst", {63'h0, stray}, 64'h0);
    end
    run_op("mult 3*4", OpMult, 32'd3, 32'd4, 32'd0, 32'd12, MulBusy, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
